// File: rtl/fetch_buffer.sv
// fetch_buffer: PC generator, one-outstanding imem fetch handshake and DEPTH-entry {pc, instr} decode queue.
// FETCH_ALIGN_CHECK_EN: misaligned REGF targets raise a sticky fault and stop fetching until reset.
module fetch_buffer #(
  parameter int W = 32,
  parameter int DEPTH = 4,
  parameter logic [W-1:0] RESET_PC = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         redir_valid,
  input  logic [1:0]   redir_src,
  input  logic         redir_taken,
  input  logic [W-1:0] redir_pc,
  input  logic [25:0]  redir_jaddr,
  input  logic [15:0]  redir_imm,
  input  logic [W-1:0] redir_reg,
  output logic         imem_req,
  output logic [W-1:0] imem_addr,
  input  logic         imem_ready,
  input  logic         imem_rvalid,
  input  logic [31:0]  imem_rdata,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_pc,
  output logic [31:0]  out_instr,
  output logic         fault
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [1:0] JUMP = 2'd1, BRCH = 2'd2, REGF = 2'd3;
  localparam logic [AW+1:0] LIMIT = (AW+2)'(DEPTH);
  logic [W-1:0] fetch_pc, req_pc, pc4, target, reg_tgt;
  logic [W-1:0] q_pc [DEPTH];
  logic [31:0] q_instr [DEPTH];
  logic [AW-1:0] head, wr;
  logic [AW:0] count;
  logic outstanding, kill, pending, accept, resp, push, pop, redir, bad;
`ifdef FETCH_ALIGN_CHECK_EN
  assign reg_tgt = redir_reg;
  assign bad = redir && redir_src == REGF && redir_reg[1:0] != 2'b00;
`else
  logic unused_lsb;
  assign unused_lsb = ^redir_reg[1:0];
  assign reg_tgt = {redir_reg[W-1:2], 2'b00};
  assign bad = 1'b0;
`endif
  always_comb begin
    pc4 = redir_pc + W'(4);
    target = redir_src == JUMP ? {pc4[W-1:28], redir_jaddr, 2'b00}
           : redir_src == BRCH ? pc4 + {{(W-18){redir_imm[15]}}, redir_imm, 2'b00}
           : reg_tgt;
  end
  // NEXT and not-taken branches leave the pipeline untouched; once faulted, fetch_pc is frozen
  assign redir = redir_valid && !fault &&
                 (redir_src == JUMP || redir_src == REGF || (redir_src == BRCH && redir_taken));
  assign pending = outstanding && !kill;
  assign imem_req = !outstanding && ({1'b0, count} + (AW+2)'(pending)) < LIMIT && !fault;
  assign imem_addr = fetch_pc;
  assign accept = imem_req && imem_ready;
  assign resp = imem_rvalid && outstanding;
  assign push = resp && !kill && !redir;
  assign out_valid = count != '0;
  assign pop = out_valid && out_ready && !redir;
  assign wr = head + count[AW-1:0];
  assign out_pc = q_pc[head];
  assign out_instr = q_instr[head];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      fetch_pc <= RESET_PC;
      req_pc <= '0;
      head <= '0;
      count <= '0;
      outstanding <= 1'b0;
      kill <= 1'b0;
      fault <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        q_pc[i] <= '0;
        q_instr[i] <= '0;
      end
    end else begin
      if (accept) begin
        outstanding <= 1'b1;
        req_pc <= fetch_pc;
        fetch_pc <= fetch_pc + W'(4);
      end
      if (resp) begin
        outstanding <= 1'b0;
        kill <= 1'b0;
      end
      if (push) begin
        q_pc[wr] <= req_pc;
        q_instr[wr] <= imem_rdata;
      end
      if (pop) head <= head + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
      if (redir) begin
        fetch_pc <= target;
        count <= '0;
        kill <= accept || (outstanding && !imem_rvalid);
        if (bad) fault <= 1'b1;
      end
    end
endmodule

// File: tb/tb_fetch_buffer.sv
// tb_fetch_buffer: randomized + directed bench for fetch_buffer against a queue-based reference model.
module tb_fetch_buffer;
  localparam int DEPTH = 4;
  logic clk = 1'b0, rst = 1'b1;
  logic redir_valid = 0, redir_taken = 0, imem_ready = 0, imem_rvalid = 0, out_ready = 0;
  logic [1:0] redir_src = 0;
  logic [31:0] redir_pc = 0, redir_reg = 0, imem_rdata = 0;
  logic [25:0] redir_jaddr = 0;
  logic [15:0] redir_imm = 0;
  logic imem_req, out_valid, fault;
  logic [31:0] imem_addr, out_pc, out_instr;

  fetch_buffer #(.W(32), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .redir_valid(redir_valid), .redir_src(redir_src),
    .redir_taken(redir_taken), .redir_pc(redir_pc), .redir_jaddr(redir_jaddr),
    .redir_imm(redir_imm), .redir_reg(redir_reg), .imem_req(imem_req),
    .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_instr(out_instr), .fault(fault));

  always #5 clk = ~clk;

  int errors = 0, checks = 0;
  logic [63:0] m_q[$];
  logic [31:0] m_pc, m_req_pc;
  bit m_out, m_kill, m_fault;
  bit mem_busy;
  int mem_cnt, lat_lo, lat_hi;
  logic [31:0] mem_data;
  logic [31:0] dut_acc[$], dut_pop[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit m_req();
    return !m_out && (m_q.size() + ((m_out && !m_kill) ? 1 : 0)) < DEPTH && !m_fault;
  endfunction

  task automatic check_all();
    check("req", 32'(imem_req), 32'(m_req()));
    check("addr", imem_addr, m_pc);
    check("valid", 32'(out_valid), 32'(m_q.size() != 0));
    check("fault", 32'(fault), 32'(m_fault));
    if (m_q.size() != 0) begin
      check("out_pc", out_pc, m_q[0][63:32]);
      check("out_instr", out_instr, m_q[0][31:0]);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_pc = 0; m_req_pc = 0; m_out = 0; m_kill = 0; m_fault = 0; mem_busy = 0;
  endtask

  task automatic do_reset();
    rst = 1; redir_valid = 0; imem_ready = 0; imem_rvalid = 0; out_ready = 0;
    #3;
    model_reset();
    @(posedge clk); #1;
    rst = 0;
    check_all();
  endtask

  // Advance one cycle: memory response, reference model update, clock edge, compare.
  task automatic tick();
    bit acc, resp, eff;
    logic [31:0] pc4, tgt;
    imem_rvalid = mem_busy && mem_cnt == 0;
    imem_rdata = imem_rvalid ? mem_data : $urandom;
    if (imem_req && imem_ready) dut_acc.push_back(imem_addr);
    if (out_valid && out_ready) dut_pop.push_back(out_pc);
    acc = m_req() && imem_ready;
    resp = imem_rvalid && m_out;
    pc4 = redir_pc + 4;
    eff = redir_valid && !m_fault &&
          (redir_src == 1 || redir_src == 3 || (redir_src == 2 && redir_taken));
    if (redir_src == 1) tgt = (pc4 & 32'hF000_0000) | (32'(redir_jaddr) * 4);
    else if (redir_src == 2) tgt = pc4 + 32'(int'($signed(redir_imm)) * 4);
    else begin
`ifdef FETCH_ALIGN_CHECK_EN
      tgt = redir_reg;
`else
      tgt = redir_reg & ~32'h3;
`endif
    end
    if (eff) begin
`ifdef FETCH_ALIGN_CHECK_EN
      if (redir_src == 3 && redir_reg % 4 != 0) m_fault = 1;
`endif
      m_kill = acc || (m_out && !imem_rvalid);
      m_out = m_kill;
      m_q.delete();
      m_pc = tgt;
    end else begin
      if (m_q.size() != 0 && out_ready) void'(m_q.pop_front());
      if (resp) begin
        if (!m_kill) m_q.push_back({m_req_pc, imem_rdata});
        m_kill = 0;
        m_out = 0;
      end
      if (acc) begin
        m_req_pc = m_pc;
        m_pc = m_pc + 4;
        m_out = 1;
      end
    end
    if (imem_rvalid) mem_busy = 0;
    else if (mem_busy) mem_cnt--;
    if (acc) begin
      mem_busy = 1;
      mem_cnt = $urandom_range(lat_lo, lat_hi);
      mem_data = $urandom;
    end
    @(posedge clk); #1;
    check_all();
  endtask

  task automatic redirect(input logic [1:0] src, input bit taken, input logic [31:0] pc,
                          input logic [25:0] ja, input logic [15:0] imm, input logic [31:0] rg);
    redir_valid = 1; redir_src = src; redir_taken = taken; redir_pc = pc;
    redir_jaddr = ja; redir_imm = imm; redir_reg = rg;
    tick();
    redir_valid = 0;
  endtask

  initial begin
    lat_lo = 0; lat_hi = 0;
    model_reset();
    #2;
    do_reset();
    check("rst_valid", 32'(out_valid), 32'h0);
    check("rst_pc", out_pc, 32'h0);
    check("rst_instr", out_instr, 32'h0);
    check("rst_req", 32'(imem_req), 32'h1);
    check("rst_addr", imem_addr, 32'h0);

    // Streaming with single-cycle memory
    imem_ready = 1; out_ready = 1;
    dut_acc.delete(); dut_pop.delete();
    for (int i = 0; i < 12; i++) tick();
    check("n_acc", 32'(dut_acc.size() >= 4), 32'h1);
    check("n_pop", 32'(dut_pop.size() >= 4), 32'h1);
    for (int i = 0; i < 4; i++) begin
      if (i < dut_acc.size()) check("seq_addr", dut_acc[i], 32'(i * 4));
      if (i < dut_pop.size()) check("seq_pc", dut_pop[i], 32'(i * 4));
    end

    // Backpressure: queue fills to DEPTH, then fetching stops
    do_reset();
    imem_ready = 1; out_ready = 0; dut_acc.delete();
    for (int i = 0; i < 20; i++) tick();
    check("bp_acc", 32'(dut_acc.size()), 32'(DEPTH));
    check("bp_req", 32'(imem_req), 32'h0);
    out_ready = 1;
    for (int i = 0; i < 6; i++) tick();
    check("bp_resume", 32'(dut_acc.size() > DEPTH), 32'h1);

    // Taken branch while the 0x10C fetch is in flight
    do_reset();
    lat_lo = 3; lat_hi = 3;
    redirect(2'd3, 0, 0, 0, 0, 32'h10C);
    check("pre_addr", imem_addr, 32'h10C);
    imem_ready = 1; tick(); imem_ready = 0;
    redirect(2'd2, 1, 32'h100, 0, 16'hFFFE, 0);
    check("br_addr", imem_addr, 32'hFC);
    check("br_valid", 32'(out_valid), 32'h0);
    imem_ready = 1;
    for (int i = 0; i < 14; i++) tick();
    check("br_head", out_pc, 32'hFC);

    // Jump keeps the upper PC bits of the redirecting instruction
    lat_lo = 0; lat_hi = 0;
    redirect(2'd1, 0, 32'hF000_0000, 26'h40, 0, 0);
    check("jmp_addr", imem_addr, 32'hF000_0100);
    for (int i = 0; i < 20; i++) tick();
    check("jmp_head", out_pc, 32'hF000_0100);

    // NEXT and not-taken branch are no-ops
    redirect(2'd0, 0, 32'h40, 0, 16'h10, 32'h800);
    redirect(2'd2, 0, 32'h40, 0, 16'h10, 32'h800);
    check("nop_valid", 32'(out_valid), 32'h1);
    check("nop_head", out_pc, 32'hF000_0100);
    check("nop_addr", imem_addr, 32'hF000_0110);

    // Misaligned register jump
    redirect(2'd3, 0, 0, 0, 0, 32'h1002);
`ifdef FETCH_ALIGN_CHECK_EN
    check("regf_fault", 32'(fault), 32'h1);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("regf_req", 32'(imem_req), 32'h0);
    end
`else
    check("regf_addr", imem_addr, 32'h1000);
`endif

    // Stale response from before reset must be ignored
    do_reset();
    mem_busy = 1; mem_cnt = 0; mem_data = 32'hDEAD_BEEF;
    tick(); tick();
    check("stale_valid", 32'(out_valid), 32'h0);

    // Randomized traffic
    lat_lo = 0; lat_hi = 2;
    for (int i = 0; i < 4000; i++) begin
      if (i % 700 == 0) do_reset();
      imem_ready = $urandom_range(0, 3) != 0;
      out_ready = $urandom_range(0, 2) != 0;
      redir_valid = $urandom_range(0, 11) == 0;
      redir_src = 2'($urandom);
      redir_taken = 1'($urandom);
      redir_pc = $urandom & ~32'h3;
      redir_jaddr = 26'($urandom);
      redir_imm = 16'($urandom);
      redir_reg = $urandom;
      if ($urandom_range(0, 7) != 0) redir_reg = redir_reg & ~32'h3;
      tick();
    end
    redir_valid = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fetch_buffer.md
# fetch_buffer

Parametrised instruction-fetch front end: holds the program counter, issues fetch requests to instruction memory over a request/response handshake, and buffers returned instructions with their PCs in a DEPTH-entry queue for decode. Redirects (jump, taken branch, register jump) from the execute stage reload the PC, flush the queue and discard any in-flight response. It replaces the single-register PC generator in each core of the dual-core processor.

## Interface
- W, 32, PC/address width; must be >= 32.
- DEPTH, 4, queue entries; power of two, >= 2.
- RESET_PC, 0, PC loaded on reset.

- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- redir_valid  in  1  redirect request this cycle.
- redir_src  in  2  0 NEXT (no-op), 1 JUMP, 2 BRCH, 3 REGF.
- redir_taken  in  1  branch outcome; only used when redir_src = BRCH.
- redir_pc  in  W  PC of the redirecting instruction.
- redir_jaddr  in  26  jump target field.
- redir_imm  in  16  branch offset, in words.
- redir_reg  in  W  register-jump target.
- imem_req  out  1  fetch request valid.
- imem_addr  out  W  fetch address.
- imem_ready  in  1  memory accepts request when imem_req && imem_ready.
- imem_rvalid  in  1  response valid.
- imem_rdata  in  32  response instruction.
- out_valid  out  1  queue head valid.
- out_ready  in  1  decode pops head when out_valid && out_ready.
- out_pc  out  W  PC of head entry.
- out_instr  out  32  instruction of head entry.
- fault  out  1  alignment fault, sticky (only with FETCH_ALIGN_CHECK_EN).

## Operation
- State: fetch_pc, queue (DEPTH x {pc, instr}), count, one outstanding-request flag, one kill flag.
- Reset: fetch_pc = RESET_PC, count = 0, outstanding = 0, kill = 0, fault = 0; out_valid = 0, out_pc = 0, out_instr = 0.
- imem_req = !outstanding && (count + pending < DEPTH) && !fault, where pending = 1 if an unkilled response is still expected; imem_addr = fetch_pc. Both are combinational from registered state only.
- On accept: outstanding <= 1, fetch_pc <= fetch_pc + 4. Exactly one request is outstanding at a time.
- On imem_rvalid: outstanding <= 0; if kill = 0, push {pc of request, imem_rdata}; if kill = 1, drop and clear kill.
- Redirect targets (pc4 = redir_pc + 4): JUMP = {pc4[W-1:28], redir_jaddr, 2'b00}; BRCH taken = pc4 + (sext(redir_imm) << 2), modulo 2^W; REGF = redir_reg. NEXT and BRCH not-taken are no-ops: no flush and no PC change.
- An effective redirect sets fetch_pc <= target and count <= 0. It sets kill <= 1 if a request is outstanding, or is accepted in the same cycle, and its response has not arrived in that cycle. A response arriving in the redirect cycle is dropped.
- Simultaneous events: redirect beats push, pop and request-PC increment. Push and pop in the same cycle leave count unchanged, and this is legal when full because the slot was reserved at request time.
- Reset mid-operation clears everything immediately. A response arriving after reset for a pre-reset request is ignored because outstanding = 0.

## Timing
- First imem_req (addr RESET_PC) is asserted in the first cycle after rst deasserts.
- Response in cycle N gives out_valid in cycle N+1 if the queue was empty.
- Redirect in cycle N gives out_valid = 0 and imem_addr = target in cycle N+1.
- Single-cycle memory (rvalid the cycle after accept) gives one request every 2 cycles.
- Pop in cycle N: the next head is visible in cycle N+1.

## Configuration
- FETCH_ALIGN_CHECK_EN defined: if a REGF target has [1:0] != 0, fault <= 1, the queue is flushed, and imem_req is held at 0 until reset. fetch_pc holds the misaligned target for debug.
- Not defined: the REGF target has [1:0] forced to 2'b00 and fault is tied to 0.

## Test plan
- Reset, memory ready with 1-cycle response, out_ready = 1 -> imem_addr sequence 0, 4, 8, C and out_pc in the same order with the matching instr.
- DEPTH = 4, out_ready = 0 -> exactly 4 accepts, then imem_req = 0. Raising out_ready resumes requests.
- Branch with redir_pc = 0x100, imm = 0xFFFE, taken, while a request to 0x10C is outstanding -> queue flushed, the 0x10C response is dropped, and the next imem_addr is 0xFC.
- JUMP with redir_pc = 0xF000_0000, jaddr = 0x0000040 -> next imem_addr is 0xF000_0100.
- BRCH not-taken and NEXT redirects -> no flush and the queue contents are unchanged.
- REGF with redir_reg = 0x1002: with the macro, fault = 1 and imem_req stays 0; without it, next imem_addr is 0x1000.
